// File: rtl/temporizador_pkg.sv
// Shared types and segment constants for the two-digit BCD countdown timer.
package temporizador_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    CONTANDO = 2'd1,
    PAUSADO  = 2'd2,
    FIM      = 2'd3
  } estado_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-low gfedcba glyphs
  localparam logic [6:0] SEG_TRACO   = 7'b0111111;
  localparam logic [6:0] SEG_C       = 7'b1000110;
  localparam logic [6:0] SEG_P       = 7'b0001100;
  localparam logic [6:0] SEG_F       = 7'b0001110;
  localparam logic [6:0] SEG_APAGADO = 7'b1111111;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/temporizador_bcd_decod7seg.sv
// BCD to active-low 7-segment (gfedcba) decoder; non-BCD codes blank the digit.
module decod7seg
  import temporizador_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_APAGADO;
    case (bcd)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_APAGADO;
    endcase
  end

endmodule

// File: rtl/temporizador_bcd.sv
// Two-digit BCD countdown timer with prescaled tick, run/pause FSM and 7-segment decode.
module temporizador_bcd
  import temporizador_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       carregar,
  input  logic [3:0] carga_dez,
  input  logic [3:0] carga_unid,
  input  logic       iniciar,
  input  logic       pausar,
  output logic [6:0] unid_out,
  output logic [6:0] dez_out,
  output logic [6:0] estado_out,
  output logic       fim
);

  localparam int unsigned PW = $clog2(DIV);

  estado_t       state;
  logic [3:0]    dez;
  logic [3:0]    unid;
  logic [PW-1:0] presc;
  logic          tick;
  logic          start;

  assign tick  = (state == CONTANDO) && (presc == PW'(DIV - 1));
  assign start = iniciar && ((state == OCIOSO) || (state == PAUSADO));

  // Priority: reset > carregar > iniciar > pausar > tick
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= OCIOSO;
      dez   <= 4'd0;
      unid  <= 4'd0;
      presc <= '0;
    end else if (carregar) begin
      state <= OCIOSO;
      dez   <= clamp_bcd(carga_dez);
      unid  <= clamp_bcd(carga_unid);
      presc <= '0;
    end else if (start) begin
      // Resuming from pause keeps the partial prescaler count
      if (state == OCIOSO) presc <= '0;
      state <= CONTANDO;
    end else if (pausar && (state == CONTANDO)) begin
      state <= PAUSADO;
    end else if (state == CONTANDO) begin
      if ((dez == 4'd0) && (unid == 4'd0)) begin
        state <= FIM;
      end else if (tick) begin
        presc <= '0;
        if (unid != 4'd0) begin
          unid <= unid - 4'd1;
          if ((unid == 4'd1) && (dez == 4'd0)) state <= FIM;
        end else begin
          unid <= BCD_MAX;
          dez  <= dez - 4'd1;
        end
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  decod7seg u_dec_unid (.bcd(unid), .seg(unid_out));
  decod7seg u_dec_dez  (.bcd(dez),  .seg(dez_out));

  always_comb begin
    estado_out = SEG_TRACO;
    case (state)
      OCIOSO:   estado_out = SEG_TRACO;
      CONTANDO: estado_out = SEG_C;
      PAUSADO:  estado_out = SEG_P;
      FIM:      estado_out = SEG_F;
      default:  estado_out = SEG_TRACO;
    endcase
  end

  assign fim = (state == FIM);

endmodule

// File: tb/tb_temporizador_bcd.sv
// Directed self-checking bench for temporizador_bcd with DIV=4.
module tb_temporizador_bcd;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       carregar = 1'b0;
  logic [3:0] carga_dez = 4'd0;
  logic [3:0] carga_unid = 4'd0;
  logic       iniciar = 1'b0;
  logic       pausar = 1'b0;
  logic [6:0] unid_out;
  logic [6:0] dez_out;
  logic [6:0] estado_out;
  logic       fim;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] G_TRACO = 7'b0111111;
  localparam logic [6:0] G_C = 7'b1000110;
  localparam logic [6:0] G_P = 7'b0001100;
  localparam logic [6:0] G_F = 7'b0001110;

  temporizador_bcd #(.DIV(4)) dut (
    .clock(clock), .reset(reset), .carregar(carregar),
    .carga_dez(carga_dez), .carga_unid(carga_unid),
    .iniciar(iniciar), .pausar(pausar),
    .unid_out(unid_out), .dez_out(dez_out),
    .estado_out(estado_out), .fim(fim)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [3:0] d, input logic [3:0] u);
    carregar = 1'b1; carga_dez = d; carga_unid = u;
    edges(1);
    carregar = 1'b0;
  endtask

  task automatic start();
    iniciar = 1'b1;
    edges(1);
    iniciar = 1'b0;
  endtask

  initial begin
    edges(3);
    check("rst_unid", unid_out, S0);
    check("rst_dez", dez_out, S0);
    check("rst_estado", estado_out, G_TRACO);
    check("rst_fim", {6'b0, fim}, 7'd0);
    reset = 1'b0;

    // Load 12, count down with borrow
    load(4'd1, 4'd2);
    check("ld12_dez", dez_out, S1);
    check("ld12_unid", unid_out, S2);
    check("ld12_estado", estado_out, G_TRACO);
    start();
    check("run_estado", estado_out, G_C);
    check("run_fim", {6'b0, fim}, 7'd0);
    edges(3);
    check("pre_tick_unid", unid_out, S2);
    edges(1);
    check("tick1_unid", unid_out, S1);
    edges(4);
    check("tick2_unid", unid_out, S0);
    check("tick2_dez", dez_out, S1);
    edges(4);
    check("borrow_dez", dez_out, S0);
    check("borrow_unid", unid_out, S9);

    // Load 01, expire
    load(4'd0, 4'd1);
    start();
    edges(4);
    check("exp_unid", unid_out, S0);
    check("exp_dez", dez_out, S0);
    check("exp_estado", estado_out, G_F);
    check("exp_fim", {6'b0, fim}, 7'd1);
    start();
    edges(3);
    check("fim_hold_estado", estado_out, G_F);
    check("fim_hold_unid", unid_out, S0);

    // Load 25, pause mid-prescale, resume keeps prescaler
    load(4'd2, 4'd5);
    start();
    edges(2);
    pausar = 1'b1;
    edges(1);
    pausar = 1'b0;
    check("pause_estado", estado_out, G_P);
    edges(10);
    check("pause_dez", dez_out, S2);
    check("pause_unid", unid_out, S5);
    check("pause_estado2", estado_out, G_P);
    start();
    check("resume_estado", estado_out, G_C);
    edges(1);
    check("resume_unid_hold", unid_out, S5);
    edges(1);
    check("resume_dec", unid_out, S4);

    // Clamp and load-over-iniciar priority
    carregar = 1'b1; iniciar = 1'b1; carga_dez = 4'd12; carga_unid = 4'd15;
    edges(1);
    carregar = 1'b0; iniciar = 1'b0;
    check("clamp_dez", dez_out, S9);
    check("clamp_unid", unid_out, S9);
    check("clamp_estado", estado_out, G_TRACO);
    edges(2);
    check("idle_stays", estado_out, G_TRACO);
    check("idle_unid", unid_out, S9);

    // Zero start
    load(4'd0, 4'd0);
    start();
    check("zero_run", estado_out, G_C);
    edges(1);
    check("zero_fim_estado", estado_out, G_F);
    check("zero_fim", {6'b0, fim}, 7'd1);

    // Reset mid-count overrides everything
    load(4'd3, 4'd3);
    start();
    edges(5);
    check("mid_unid", unid_out, 7'b0100100);
    reset = 1'b1; carregar = 1'b1; iniciar = 1'b1; carga_dez = 4'd7; carga_unid = 4'd7;
    edges(1);
    check("mrst_unid", unid_out, S0);
    check("mrst_dez", dez_out, S0);
    check("mrst_estado", estado_out, G_TRACO);
    check("mrst_fim", {6'b0, fim}, 7'd0);
    reset = 1'b0; carregar = 1'b0; iniciar = 1'b0;
    edges(2);
    check("post_rst_estado", estado_out, G_TRACO);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
